fifo_bram_fwft: RTL and testbench
=================================

# fifo_bram_fwft

Parametrised first-word-fall-through FIFO built on a single-clock simple dual-port RAM with a synchronous write port and a synchronous read port, so its storage infers block RAM. It adds pointer management, occupancy counting, a valid/ready handshake on both sides, a flush, and an almost-full threshold. It sits between the MAC byte streams and the TX/RX framers, buffering frames that arrive faster than they can be consumed.

## Interface
- W, 8, data word width in bits (≥1)
- D, 128, capacity in words (≥2; need not be a power of two)
- AF_LEVEL, D-4, almost_full threshold in words (1..D)
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of contents, active-high
- in_valid  in  1  producer offers in_data
- in_ready  out  1  FIFO can accept a word this cycle
- in_data  in  W  write word
- out_valid  out  1  out_data holds the oldest unpopped word
- out_ready  in  1  consumer takes out_data this cycle
- out_data  out  W  head word, registered
- count  out  $clog2(D+1)  words accepted and not yet popped
- almost_full  out  1  count ≥ AF_LEVEL
- overflow  out  1  one-cycle pulse: in_valid while in_ready low

## Operation
- Accept: in_valid && in_ready at an edge writes in_data at wr_ptr; wr_ptr advances.
- Pop: out_valid && out_ready at an edge retires the head; rd_ptr advances.
- Pointers wrap from D-1 to 0. Storage is a W×D RAM with synchronous write, synchronous read, and no reset on array contents.
- Read address is driven combinationally:
  - it is the next head address when a pop occurs, otherwise the current head address;
  - this lets the RAM output register refill the head every cycle.
- count:
  - +1 on accept only, −1 on pop only;
  - unchanged on accept and pop in the same cycle;
  - never exceeds D and never goes below 0.
- in_ready = (count < D) and not in reset.
  - in_ready does not depend on out_ready: when full, a pop and a write in the same cycle are not allowed.
  - The write is refused and overflow pulses.
- almost_full and in_ready are derived combinationally from registered count.
- overflow is registered: it is high for the cycle after any edge where in_valid=1 and in_ready=0. It is not sticky.
- flush (when rst_n=1) has the same effect as reset on pointers, count, and out_valid.
  - A write or pop in the flush cycle is discarded.
  - overflow is not asserted by a flush cycle.
- Read-during-write to the same RAM address returns old data. The FIFO never relies on that read; see Timing.

## Timing
- Reset, after any edge with rst_n=0:
  - out_valid=0, out_data=0, count=0, almost_full=0 (unless AF_LEVEL=0, which is disallowed), overflow=0, pointers=0;
  - in_ready is forced to 0 while rst_n=0.
  - Reset asserted mid-stream discards all contents. No partial word is ever presented.
- Fall-through latency:
  - A word accepted at edge E into an empty FIFO gives out_valid=1 with that word on out_data after edge E+1.
  - It is never presented after edge E.
- Sustained throughput: with count ≥ 2, one pop per cycle indefinitely, with out_valid held high.
- One-word corner: count=1, pop of the head and accept of a new word at the same edge E.
  - After E: out_valid=0 and count=1.
  - After E+1: out_valid=1 with the new word.
  - This one-cycle bubble is required; presenting stale RAM data is a failure.
- out_data holds its value while out_valid=1 and out_ready=0.
- When out_valid=0, out_data is don't-care. After reset or flush it reads 0.
- Full: count=D → in_ready=0 in the same cycle. A pop at edge E restores in_ready=1 after E.

## Test plan
- Reset/idle:
  - Stimulus: hold rst_n=0 for 3 cycles, then release with in_valid=0.
  - Required: out_valid=0, count=0, in_ready=1, out_data=0, overflow=0.
- Fall-through:
  - Stimulus: write 0xA5 at edge E into an empty FIFO, with W=8, D=8.
  - Required: out_valid=1 and out_data=0xA5 after E+1, and not after E.
  - Then pop: count=0 and out_valid=0.
- Fill/overflow/wrap:
  - Stimulus: D=8, AF_LEVEL=6. Write 0..9 continuously.
  - Required:
    - almost_full rises after the 6th accept;
    - in_ready=0 after the 8th accept;
    - writes 8 and 9 each cause a one-cycle overflow pulse.
  - Then stream pops and writes 10..25.
  - Required: pops return 0..7, then 10..25 in order across pointer wrap.
- Back-to-back streaming:
  - Stimulus: with count ≥ 2, out_ready=1 and in_valid=1 each cycle for 50 cycles.
  - Required: out_valid never drops, count constant, data order preserved.
- One-word corner:
  - Stimulus: count=1 holding 0x11; at the same edge, pop and write 0x22.
  - Required: one-cycle out_valid=0 bubble, then 0x22. 0x11 is never repeated.
- Flush/reset mid-operation:
  - Stimulus: with count=5, assert flush for one cycle with a simultaneous write.
  - Required: count=0, out_valid=0, the write is discarded, and the next written word falls through normally.
  - Repeat with rst_n=0 instead of flush: same result.

Source files
------------

// File: rtl/fifo_bram_fwft.sv
`default_nettype none
// ============================================================================
// Module   : fifo_bram_fwft
// Brief    : First-word-fall-through FIFO on a block-RAM style dual-port array.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_bram_fwft #(
    parameter int W        = 8,
    parameter int D        = 128,
    parameter int AF_LEVEL = D - 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic [$clog2(D+1)-1:0] count,
    output logic                   almost_full,
    output logic                   overflow
);

    localparam int PW = $clog2(D);
    localparam int CW = $clog2(D + 1);
    localparam logic [PW-1:0] LAST_ADDR = PW'(D - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(D);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_next;
    logic [PW-1:0] rd_next;
    logic [PW-1:0] raddr;
    logic          accept;
    logic          pop;

    assign in_ready    = rst_n && (count < FULL_CNT);
    assign almost_full = (count >= AF_CNT);
    assign accept      = in_valid && in_ready && !flush;
    assign pop         = out_valid && out_ready && !flush;
    assign wr_next     = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + PW'(1);
    assign rd_next     = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + PW'(1);
    // Look one slot ahead on a pop so the RAM output register holds the new head.
    assign raddr       = pop ? rd_next : rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_next;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Only words stored before this edge are readable next cycle; a word
            // written now would collide with the read and return stale data.
            out_valid <= pop ? (count > CW'(1)) : (count != '0);
            overflow  <= in_valid && !in_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            out_data <= '0;
        end else begin
            out_data <= mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_bram_fwft.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_bram_fwft
// Brief    : Directed self-checking bench for fifo_bram_fwft (W=8, D=8, AF=6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_bram_fwft;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] count;
    logic       almost_full;
    logic       overflow;

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] q[$];

    fifo_bram_fwft #(.W(8), .D(8), .AF_LEVEL(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .almost_full(almost_full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int popped;
        int nxt;
        logic [7:0] expq[$];

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        // Reset / idle
        tick(); tick(); tick();
        chk("in_ready_in_reset", in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_almost_full", almost_full, 0);

        // Fall-through
        wr(8'hA5);
        chk("ft_not_after_E", out_valid, 0);
        chk("ft_count", count, 1);
        tick();
        chk("ft_valid_E1", out_valid, 1);
        chk("ft_data_E1", out_data, 8'hA5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ft_pop_count", count, 0);
        chk("ft_pop_valid", out_valid, 0);

        // Fill / overflow
        for (int i = 0; i < 10; i++) begin
            int c;
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            c = (i + 1 > 8) ? 8 : i + 1;
            chk("fill_count", count, c);
            chk("fill_almost_full", almost_full, (c >= 6) ? 1 : 0);
            chk("fill_in_ready", in_ready, (c < 8) ? 1 : 0);
            chk("fill_overflow", overflow, (i >= 8) ? 1 : 0);
            chk("fill_out_valid", out_valid, (i >= 1) ? 1 : 0);
        end
        in_valid = 1'b0;
        tick();
        chk("ovf_not_sticky", overflow, 0);
        chk("fill_head", out_data, 0);

        // Drain while writing 10..25 across pointer wrap
        for (int i = 0; i < 8; i++) expq.push_back(8'(i));
        for (int i = 10; i <= 25; i++) expq.push_back(8'(i));
        for (int i = 0; i < 8; i++) q.push_back(8'(i));
        popped = 0;
        nxt = 10;
        for (int cyc = 0; cyc < 80 && popped < 24; cyc++) begin
            logic acc;
            out_ready = 1'b1;
            in_valid  = (nxt <= 25);
            in_data   = 8'(nxt);
            #1;
            chk("wrap_in_ready", in_ready, (q.size() < 8) ? 1 : 0);
            acc = in_valid && in_ready;
            if (out_valid) begin
                chk("wrap_data", out_data, expq[popped]);
                void'(q.pop_front());
                popped++;
            end
            if (acc) begin
                q.push_back(8'(nxt));
                nxt++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("wrap_popped_all", popped, 24);
        chk("wrap_count_end", count, 0);

        // Back-to-back streaming
        q.delete();
        wr(8'h30); wr(8'h31); wr(8'h32);
        q.push_back(8'h30); q.push_back(8'h31); q.push_back(8'h32);
        for (int i = 0; i < 50; i++) begin
            in_valid  = 1'b1;
            in_data   = 8'h40 + 8'(i);
            out_ready = 1'b1;
            #1;
            chk("b2b_valid", out_valid, 1);
            chk("b2b_count", count, 3);
            chk("b2b_data", out_data, q[0]);
            void'(q.pop_front());
            q.push_back(8'h40 + 8'(i));
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            if (out_valid) begin
                chk("b2b_drain", out_data, q[0]);
                void'(q.pop_front());
            end
            tick();
        end
        out_ready = 1'b0;
        chk("b2b_drained", q.size(), 0);
        chk("b2b_count_end", count, 0);

        // One-word corner
        wr(8'h11);
        tick();
        chk("ow_head", out_data, 8'h11);
        out_ready = 1'b1;
        wr(8'h22);
        chk("ow_bubble", out_valid, 0);
        chk("ow_count", count, 1);
        tick();
        chk("ow_valid", out_valid, 1);
        chk("ow_data", out_data, 8'h22);
        tick();
        out_ready = 1'b0;
        chk("ow_empty", out_valid, 0);
        chk("ow_count_end", count, 0);

        // Flush mid-operation, then reset mid-operation
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 5; i++) wr(8'h50 + 8'(i));
            tick();
            chk("fl_count5", count, 5);
            if (pass == 0) flush = 1'b1; else rst_n = 1'b0;
            in_valid = 1'b1;
            in_data  = 8'h99;
            tick();
            flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
            chk("fl_count", count, 0);
            chk("fl_valid", out_valid, 0);
            chk("fl_data", out_data, 0);
            chk("fl_overflow", overflow, 0);
            tick();
            chk("fl_discard_count", count, 0);
            chk("fl_discard_valid", out_valid, 0);
            wr(8'h77);
            chk("fl_ft_not_E", out_valid, 0);
            tick();
            chk("fl_ft_valid", out_valid, 1);
            chk("fl_ft_data", out_data, 8'h77);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("fl_end_count", count, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
